// File: rtl/tc_timer_slave_pkg.sv
// Shared definitions for the tc_timer_slave memory-mapped timer:
// register offsets, CTRL bit positions, MODE encodings, FSM states
// and the byte-lane merge helper used by the bus write path.
package tc_timer_slave_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_AUX    = 4'hC;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } tc_state_e;

  // Replace only the byte lanes whose enable bit is set
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] result;
    result = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) result[8*k +: 8] = new_val[8*k +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/tc_timer_slave_prescaler.sv
// tc_prescaler: 16-bit divider producing a one-cycle tick every
// divisor+1 enabled cycles; clear forces the divider back to zero.
module tc_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] divisor,
  output logic        tick
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Tick on reaching the divisor; >= guards against the divisor shrinking mid-count
  assign tick = enable && (cnt_q >= divisor);

  // Next divider value: clear wins, otherwise count and wrap on tick
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 16'h0;
    end else if (enable) begin
      cnt_d = tick ? 16'h0 : cnt_q + 16'h1;
    end
  end

  // Divider register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 16'h0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tc_timer_slave.sv
// tc_timer_slave: memory-mapped down-counter with one-shot and
// auto-reload modes on the CPU data bus; drives the CPU interrupt.
// Optional macro TC_PRESCALE_EN adds a PRESCALE register at 0xC and
// a tc_prescaler that paces the decrements.
module tc_timer_slave
  import tc_timer_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e   state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        hit;
  logic        wr;
  logic [3:0]  off;
  logic        wr_ctrl;
  logic        wr_preset;
  logic [3:0]  ctrl_bus;
  logic        en_now;
  logic        presc_clear;
  logic        tick;
  logic        unused_addr_lsb;

  assign hit             = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr              = hit && (|byteen);
  assign off             = {addr[3:2], 2'b00};
  assign wr_ctrl         = wr && (off == OFF_CTRL);
  assign wr_preset       = wr && (off == OFF_PRESET);
  assign unused_addr_lsb = ^addr[1:0];

  // CTRL as it will be after this edge's bus write, so EN writes act at once
  assign ctrl_bus = (wr_ctrl && byteen[0]) ? wdata[3:0] : ctrl_q;
  assign en_now   = ctrl_bus[CTRL_EN];

  assign irq = irq_flag_q & ctrl_q[CTRL_IM];

`ifdef TC_PRESCALE_EN
  logic [15:0] prescale_q, prescale_d;
  logic        wr_aux;
  logic [31:0] prescale_merged;

  assign wr_aux          = wr && (off == OFF_AUX);
  assign prescale_merged = merge_bytes({16'h0, prescale_q}, wdata, byteen);

  // PRESCALE register write merge
  always_comb begin
    prescale_d = prescale_q;
    if (wr_aux) prescale_d = prescale_merged[15:0];
  end

  // PRESCALE register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prescale_q <= 16'h0;
    else        prescale_q <= prescale_d;
  end

  tc_prescaler u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear   (presc_clear),
    .enable  (!presc_clear),
    .divisor (prescale_q),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Combinational read mux; zero on a miss or an unmapped offset
  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      case (off)
        OFF_CTRL:   rdata = {28'h0, ctrl_q};
        OFF_PRESET: rdata = preset_q;
        OFF_COUNT:  rdata = count_q;
`ifdef TC_PRESCALE_EN
        OFF_AUX:    rdata = {16'h0, prescale_q};
`else
        OFF_AUX:    rdata = 32'h0;
`endif
        default:    rdata = 32'h0;
      endcase
    end
  end

  // Next state, counter, flag and register updates; bus CTRL write beats INT's EN clear, flag set beats bus clear
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    preset_d    = preset_q;
    count_d     = count_q;
    irq_flag_d  = irq_flag_q;
    presc_clear = 1'b1;

    if (wr_preset) preset_d = merge_bytes(preset_q, wdata, byteen);
    if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_now) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        presc_clear = 1'b0;
        if (!en_now) begin
          state_d = ST_IDLE;
        end else if (count_q == 32'h0) begin
          state_d    = ST_INT;
          irq_flag_d = 1'b1;
        end else if (tick) begin
          count_d = count_q - 32'h1;
        end
      end
      ST_INT: begin
        if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
          state_d    = ST_LOAD;
          irq_flag_d = 1'b0;
        end else begin
          state_d         = ST_IDLE;
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_ctrl && byteen[0]) ctrl_d = wdata[3:0];
  end

  // State and register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'h0;
      preset_q   <= 32'h0;
      count_q    <= 32'h0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

endmodule

// File: tb/tb_tc_timer_slave.sv
// Testbench for tc_timer_slave: register-access vector table followed
// by hand-written timing sequences (one-shot, auto-reload, collisions,
// masked interrupt, mid-count reset, optional prescaler).
module tb_tc_timer_slave;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_AUX    = BASE + 32'hC;
`ifdef TC_PRESCALE_EN
  localparam logic [31:0] PS_EXP = 32'h0000_FFFF;
`else
  localparam logic [31:0] PS_EXP = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  byteen = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        irq;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[21];

  tc_timer_slave #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  // Free-running clock, posedges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one bus write, let it land on the next edge, return 1 time unit after it
  task automatic applyStimulus(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    addr = a;
    byteen = be;
    wdata = wd;
    @(posedge clk);
    #1;
    byteen = 4'h0;
    wdata = 32'h0;
  endtask

  task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    byteen = 4'h0;
    #1;
    checkOutput(name, rdata, exp);
  endtask

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0]  = '{A_CTRL,   4'h0, 32'h0,          32'h0,          1'b0};
    vecs[1]  = '{A_PRESET, 4'h0, 32'h0,          32'h0,          1'b0};
    vecs[2]  = '{A_COUNT,  4'h0, 32'h0,          32'h0,          1'b0};
    vecs[3]  = '{A_PRESET, 4'hF, 32'h1122_3344,  32'h0,          1'b0};
    vecs[4]  = '{A_PRESET, 4'h2, 32'h0000_AB00,  32'h1122_3344,  1'b0};
    vecs[5]  = '{A_PRESET, 4'h0, 32'h0,          32'h1122_AB44,  1'b0};
    vecs[6]  = '{A_COUNT,  4'hF, 32'hFFFF_FFFF,  32'h0,          1'b0};
    vecs[7]  = '{A_COUNT,  4'h0, 32'h0,          32'h0,          1'b0};
    vecs[8]  = '{BASE + 32'h10, 4'hF, 32'hFFFF_FFFF, 32'h0,      1'b0};
    vecs[9]  = '{32'h0001_7F04, 4'hF, 32'h0,     32'h0,          1'b0};
    vecs[10] = '{A_PRESET, 4'h0, 32'h0,          32'h1122_AB44,  1'b0};
    vecs[11] = '{A_CTRL,   4'h0, 32'h0,          32'h0,          1'b0};
    vecs[12] = '{BASE + 32'h3, 4'h1, 32'h0000_0008, 32'h0,       1'b0};
    vecs[13] = '{BASE + 32'h1, 4'h0, 32'h0,      32'h8,          1'b0};
    vecs[14] = '{A_CTRL,   4'hF, 32'hFFFF_FFF6,  32'h8,          1'b0};
    vecs[15] = '{A_CTRL,   4'h0, 32'h0,          32'h6,          1'b0};
    vecs[16] = '{A_CTRL,   4'hF, 32'h0,          32'h6,          1'b0};
    vecs[17] = '{A_AUX,    4'hF, 32'hFFFF_FFFF,  32'h0,          1'b0};
    vecs[18] = '{A_AUX,    4'h0, 32'h0,          PS_EXP,         1'b0};
    vecs[19] = '{A_AUX,    4'hF, 32'h0,          PS_EXP,         1'b0};
    vecs[20] = '{A_AUX,    4'h0, 32'h0,          32'h0,          1'b0};

    // Reset held, then released between edges
    #2;
    checkOutput("irq_in_reset", {31'h0, irq}, 32'h0);
    #20;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Register access table: check pre-edge outputs, then let any write land
    for (int i = 0; i < 21; i++) begin
      addr = vecs[i].addr;
      byteen = vecs[i].be;
      wdata = vecs[i].wdata;
      #1;
      checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
      @(posedge clk);
      #1;
    end
    byteen = 4'h0;

    // One-shot, PRESET=3: irq after E0+5, EN self-clears
    applyStimulus(A_PRESET, 4'hF, 32'd3);
    applyStimulus(A_CTRL, 4'hF, 32'h9);
    waitEdges(1);
    readCheck("os_count_e1", A_COUNT, 32'd3);
    waitEdges(3);
    readCheck("os_count_e4", A_COUNT, 32'd0);
    checkOutput("os_irq_e4", {31'h0, irq}, 32'h0);
    waitEdges(1);
    checkOutput("os_irq_e5", {31'h0, irq}, 32'h1);
    waitEdges(1);
    readCheck("os_ctrl_after", A_CTRL, 32'h8);
    checkOutput("os_irq_held", {31'h0, irq}, 32'h1);
    applyStimulus(A_CTRL, 4'hF, 32'h0);
    checkOutput("os_irq_cleared", {31'h0, irq}, 32'h0);

    // PRESET=0 with collisions: flag set beats bus clear, bus CTRL beats EN clear
    applyStimulus(A_PRESET, 4'hF, 32'd0);
    applyStimulus(A_CTRL, 4'hF, 32'h9);
    waitEdges(1);
    checkOutput("p0_irq_e1", {31'h0, irq}, 32'h0);
    applyStimulus(A_PRESET, 4'hF, 32'd0);
    checkOutput("p0_set_wins", {31'h0, irq}, 32'h1);
    applyStimulus(A_CTRL, 4'hF, 32'h9);
    readCheck("p0_bus_wins_ctrl", A_CTRL, 32'h9);
    checkOutput("p0_irq_wr_clear", {31'h0, irq}, 32'h0);
    waitEdges(2);
    checkOutput("p0_irq_e5", {31'h0, irq}, 32'h0);
    waitEdges(1);
    checkOutput("p0_irq_e6", {31'h0, irq}, 32'h1);
    applyStimulus(A_CTRL, 4'hF, 32'h0);
    checkOutput("p0_irq_off", {31'h0, irq}, 32'h0);

    // Auto-reload, PRESET=2: COUNT 2,1,0,0,0 repeating; irq pulse every 5 cycles
    begin
      logic [31:0] exp_cnt[11];
      logic        exp_irq[11];
      exp_cnt = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2};
      exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      applyStimulus(A_PRESET, 4'hF, 32'd2);
      applyStimulus(A_CTRL, 4'hF, 32'hB);
      for (int k = 0; k < 11; k++) begin
        waitEdges(1);
        readCheck($sformatf("ar_count_e%0d", k + 1), A_COUNT, exp_cnt[k]);
        checkOutput($sformatf("ar_irq_e%0d", k + 1), {31'h0, irq}, {31'h0, exp_irq[k]});
      end
    end
    applyStimulus(A_CTRL, 4'hF, 32'h0);
    waitEdges(1);
    readCheck("ar_count_holds", A_COUNT, 32'd2);

    // IM=0: timer still fires (EN self-clears) but irq stays low
    applyStimulus(A_PRESET, 4'hF, 32'd1);
    applyStimulus(A_CTRL, 4'hF, 32'h1);
    for (int k = 0; k < 5; k++) begin
      waitEdges(1);
      checkOutput($sformatf("im0_irq_%0d", k), {31'h0, irq}, 32'h0);
    end
    readCheck("im0_en_cleared", A_CTRL, 32'h0);

    // Reset asserted mid-count with COUNT=5
    applyStimulus(A_PRESET, 4'hF, 32'd10);
    applyStimulus(A_CTRL, 4'hF, 32'h9);
    waitEdges(6);
    readCheck("rst_count_pre", A_COUNT, 32'd5);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_count_async", rdata, 32'h0);
    checkOutput("rst_irq_async", {31'h0, irq}, 32'h0);
    readCheck("rst_ctrl", A_CTRL, 32'h0);
    readCheck("rst_preset", A_PRESET, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    waitEdges(3);
    readCheck("rst_count_after", A_COUNT, 32'h0);
    checkOutput("rst_irq_after", {31'h0, irq}, 32'h0);

`ifdef TC_PRESCALE_EN
    // PRESCALE=1, PRESET=2: irq at E0+6
    applyStimulus(A_AUX, 4'hF, 32'd1);
    readCheck("ps_readback", A_AUX, 32'd1);
    applyStimulus(A_PRESET, 4'hF, 32'd2);
    applyStimulus(A_CTRL, 4'hF, 32'h9);
    waitEdges(5);
    checkOutput("ps_irq_e5", {31'h0, irq}, 32'h0);
    waitEdges(1);
    checkOutput("ps_irq_e6", {31'h0, irq}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
